// File: rtl/frame_fifo_arbiter.sv
// Round-robin frame arbiter: drains whole frames from two FWFT FIFOs onto one
// TX byte stream, with inter-frame gap, oversize truncation and error flags.
module frame_fifo_arbiter #(
  parameter int DATA_WIDTH    = 9,
  parameter int IFG_CYCLES    = 12,
  parameter int MAX_FRAME_LEN = 1522,
  parameter int LEN_WIDTH     = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a_dout,
  input  logic                  a_empty_flag,
  input  logic                  a_frame_avail,
  output logic                  a_ren,
  input  logic [DATA_WIDTH-1:0] b_dout,
  input  logic                  b_empty_flag,
  input  logic                  b_frame_avail,
  output logic                  b_ren,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  err_underrun,
  output logic                  err_oversize,
  output logic [15:0]           frames_sent,
  output logic [1:0]            dbg_state_o
);

  localparam int GAP_W = $clog2(IFG_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DRAIN = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 last_b_q, last_b_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 unr_q, unr_d;
  logic                 ovs_q, ovs_d;
  logic [15:0]          frames_q, frames_d;

  logic                  sel_b, sel_empty, sel_eof, sel_ren;
  logic [DATA_WIDTH-1:0] sel_dout;
  logic                  req_a, req_b, pick_b;

  assign sel_b     = grant_q[1];
  assign sel_empty = sel_b ? b_empty_flag : a_empty_flag;
  assign sel_dout  = sel_b ? b_dout : a_dout;
  assign sel_eof   = sel_dout[DATA_WIDTH-1];
  assign req_a     = a_frame_avail & ~a_empty_flag;
  assign req_b     = b_frame_avail & ~b_empty_flag;
  // On a tie the FIFO that was not served last wins.
  assign pick_b    = req_b & (~req_a | ~last_b_q);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_b_d = last_b_q;
    len_d    = len_q;
    gap_d    = gap_q;
    unr_d    = unr_q;
    ovs_d    = ovs_q;
    frames_d = frames_q;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = sel_dout[7:0];
    sel_ren  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_a | req_b) begin
          grant_d  = pick_b ? 2'b10 : 2'b01;
          last_b_d = pick_b;
          len_d    = '0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        tx_valid = ~sel_empty;
        tx_last  = tx_valid & (sel_eof | (len_q == LEN_WIDTH'(MAX_FRAME_LEN - 1)));
        sel_ren  = tx_valid & tx_ready;
        if (sel_empty) unr_d = 1'b1;
        if (sel_ren) begin
          len_d = len_q + LEN_WIDTH'(1);
          if (tx_last) begin
            frames_d = frames_q + 16'd1;
            if (sel_eof) begin
              grant_d = 2'b00;
              gap_d   = GAP_W'(IFG_CYCLES);
              state_d = S_GAP;
            end else begin
              // Truncated at the length limit: the rest of the frame is discarded.
              ovs_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        sel_ren = ~sel_empty;
        if (sel_ren & sel_eof) begin
          grant_d = 2'b00;
          gap_d   = GAP_W'(IFG_CYCLES);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= 2'b00;
      last_b_q <= 1'b1;
      len_q    <= '0;
      gap_q    <= '0;
      unr_q    <= 1'b0;
      ovs_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_b_q <= last_b_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      unr_q    <= unr_d;
      ovs_q    <= ovs_d;
      frames_q <= frames_d;
    end
  end

  assign a_ren        = sel_ren & ~sel_b;
  assign b_ren        = sel_ren & sel_b;
  assign grant        = grant_q;
  assign busy         = (state_q != S_IDLE);
  assign err_underrun = unr_q;
  assign err_oversize = ovs_q;
  assign frames_sent  = frames_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_frame_fifo_arbiter.sv
// Bench for frame_fifo_arbiter: FIFO models feed the DUT, a frame-level model
// predicts the byte stream, and a negedge monitor scores every handshake.
module tb_frame_fifo_arbiter;
  localparam int DW   = 9;
  localparam int IFG  = 12;
  localparam int MAXL = 8;
  localparam int LW   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] a_dout, b_dout;
  logic          a_empty_flag, b_empty_flag, a_frame_avail, b_frame_avail;
  logic          a_ren, b_ren;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_last, tx_ready;
  logic [1:0]    grant;
  logic          busy, err_underrun, err_oversize;
  logic [15:0]   frames_sent;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  frame_fifo_arbiter #(
    .DATA_WIDTH(DW), .IFG_CYCLES(IFG), .MAX_FRAME_LEN(MAXL), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_dout(a_dout), .a_empty_flag(a_empty_flag), .a_frame_avail(a_frame_avail), .a_ren(a_ren),
    .b_dout(b_dout), .b_empty_flag(b_empty_flag), .b_frame_avail(b_frame_avail), .b_ren(b_ren),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .err_underrun(err_underrun), .err_oversize(err_oversize),
    .frames_sent(frames_sent), .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] a_q[$], b_q[$];
  logic          stall_a = 1'b0, stall_b = 1'b0;
  logic [10:0]   exp_q[$];
  int            ma_len[$], mb_len[$];
  logic [7:0]    ma_byte[$], mb_byte[$];
  logic          model_last_b;
  int            exp_frames;
  logic          exp_ovs;
  logic          pop_a = 1'b0, pop_b = 1'b0;
  bit            ready_rand = 1'b0;
  bit            had_grant = 1'b0;
  int            zero_run = 0;
  logic          prev_hold = 1'b0;
  logic [7:0]    prev_data;
  logic [1:0]    prev_grant;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    logic fa, fb;
    fa = 1'b0;
    fb = 1'b0;
    foreach (a_q[i]) if (a_q[i][DW-1]) fa = 1'b1;
    foreach (b_q[i]) if (b_q[i][DW-1]) fb = 1'b1;
    a_frame_avail = fa;
    b_frame_avail = fb;
    a_empty_flag  = (a_q.size() == 0) || stall_a;
    b_empty_flag  = (b_q.size() == 0) || stall_b;
    a_dout        = (a_q.size() != 0) ? a_q[0] : '0;
    b_dout        = (b_q.size() != 0) ? b_q[0] : '0;
  endtask

  task automatic load_frame(input bit to_b, input int len, input logic [7:0] base,
                            input logic [7:0] step, input bit rnd);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = rnd ? 8'($urandom_range(0, 255)) : 8'(base + 8'(i) * step);
      if (to_b) begin
        b_q.push_back({(i == len - 1), d});
        mb_byte.push_back(d);
      end else begin
        a_q.push_back({(i == len - 1), d});
        ma_byte.push_back(d);
      end
    end
    if (to_b) mb_len.push_back(len);
    else ma_len.push_back(len);
    refresh();
  endtask

  // Whole-frame round robin over everything loaded; frames longer than the
  // limit are cut to MAXL bytes with the last flag on the final byte sent.
  task automatic build_expected();
    bit pick_b;
    int len, n_sent;
    logic [7:0] d;
    while (ma_len.size() > 0 || mb_len.size() > 0) begin
      pick_b = (mb_len.size() > 0) && (ma_len.size() == 0 || !model_last_b);
      len    = pick_b ? mb_len.pop_front() : ma_len.pop_front();
      n_sent = (len > MAXL) ? MAXL : len;
      for (int i = 0; i < len; i++) begin
        d = pick_b ? mb_byte.pop_front() : ma_byte.pop_front();
        if (i < n_sent)
          exp_q.push_back({(pick_b ? 2'b10 : 2'b01), (i == n_sent - 1), d});
      end
      if (len > MAXL) exp_ovs = 1'b1;
      exp_frames++;
      model_last_b = pick_b;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_last"}, tx_last, 0);
    chk({tag, "_ren"}, {a_ren, b_ren}, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_underrun"}, err_underrun, 0);
    chk({tag, "_err_oversize"}, err_oversize, 0);
    chk({tag, "_frames_sent"}, frames_sent, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    a_q.delete(); b_q.delete(); exp_q.delete();
    ma_len.delete(); mb_len.delete(); ma_byte.delete(); mb_byte.delete();
    stall_a = 1'b0; stall_b = 1'b0;
    model_last_b = 1'b1; exp_frames = 0; exp_ovs = 1'b0;
    had_grant = 1'b0;
    refresh();
    #1;
    check_reset_outputs(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_done(input string tag);
    int n;
    n = 0;
    while (!(a_q.size() == 0 && b_q.size() == 0 && exp_q.size() == 0) && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d bytes pending expected 0", tag, exp_q.size());
      a_q.delete(); b_q.delete(); exp_q.delete();
      refresh();
    end
    repeat (IFG + 4) @(posedge clk);
    #2;
  endtask

  // FIFO pops and ready randomisation, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (pop_a && a_q.size() > 0) a_q.delete(0);
      if (pop_b && b_q.size() > 0) b_q.delete(0);
    end
    pop_a = 1'b0;
    pop_b = 1'b0;
    if (ready_rand) tx_ready = ($urandom_range(0, 3) != 0);
    refresh();
  end

  // Monitor: scores handshakes, read-enable legality, holds and gap length.
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst_n) begin
      pop_a = a_ren;
      pop_b = b_ren;
      if (a_ren) chk("ren_a_while_empty", a_empty_flag, 0);
      if (b_ren) chk("ren_b_while_empty", b_empty_flag, 0);
      if (tx_valid && !tx_ready) chk("ren_while_not_ready", {a_ren, b_ren}, 0);
      if (prev_hold && !stall_a && !stall_b) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_grant_data", {grant, tx_data}, {prev_grant, prev_data});
      end
      prev_hold  = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_grant = grant;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got 0x%0h with nothing expected", {grant, tx_last, tx_data});
        end else begin
          e = exp_q.pop_front();
          chk("tx_grant_last_data", {grant, tx_last, tx_data}, e);
        end
      end
      if (grant == 2'b00) zero_run++;
      else begin
        if (had_grant && zero_run > 0) chk("gap_len", zero_run, IFG + 1);
        had_grant = 1'b1;
        zero_run  = 0;
      end
    end else begin
      pop_a     = 1'b0;
      pop_b     = 1'b0;
      prev_hold = 1'b0;
      zero_run  = 0;
    end
  end

  initial begin
    rst_n = 1'b0;
    tx_ready = 1'b1;
    model_last_b = 1'b1;
    exp_frames = 0;
    exp_ovs = 1'b0;
    refresh();
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame on A: 11 22 33.
    @(posedge clk);
    #2;
    load_frame(1'b0, 3, 8'h11, 8'h11, 1'b0);
    build_expected();
    run_until_done("single_a");
    chk("single_a_frames", frames_sent, 1);
    chk("single_a_idle", busy, 0);

    // Tie from reset: A wins first, then strict alternation.
    do_reset("rst_tie");
    load_frame(1'b0, 2, 8'h01, 8'h01, 1'b0);
    load_frame(1'b0, 2, 8'h03, 8'h01, 1'b0);
    load_frame(1'b1, 2, 8'h81, 8'h01, 1'b0);
    load_frame(1'b1, 2, 8'h83, 8'h01, 1'b0);
    build_expected();
    run_until_done("tie");
    chk("tie_frames", frames_sent, 4);

    // Oversize: 10-byte frame, limit 8.
    had_grant = 1'b0;
    load_frame(1'b0, 10, 8'h40, 8'h01, 1'b0);
    build_expected();
    run_until_done("oversize");
    chk("oversize_err", err_oversize, 1);
    chk("oversize_frames", frames_sent, 5);
    chk("oversize_drained", a_q.size(), 0);

    // Random frames and random backpressure.
    ready_rand = 1'b1;
    for (int r = 0; r < 5; r++) begin
      had_grant = 1'b0;
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        load_frame(1'b0, $urandom_range(1, 11), 8'h00, 8'h00, 1'b1);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        load_frame(1'b1, $urandom_range(1, 11), 8'h00, 8'h00, 1'b1);
      build_expected();
      run_until_done("random");
      chk("random_frames", frames_sent, exp_frames & 16'hFFFF);
      chk("random_err_oversize", err_oversize, exp_ovs);
      chk("random_err_underrun", err_underrun, 0);
    end
    ready_rand = 1'b0;
    tx_ready = 1'b1;

    // Underrun: A runs dry after 2 of 4 bytes for 3 cycles.
    do_reset("rst_underrun");
    load_frame(1'b0, 4, 8'hA0, 8'h01, 1'b0);
    build_expected();
    fork
      begin
        int n;
        n = 0;
        while (a_q.size() != 2 && n < 200) begin
          @(posedge clk);
          #2;
          n++;
        end
        stall_a = 1'b1;
        refresh();
        repeat (3) begin
          @(negedge clk);
          #1;
          chk("underrun_valid_low", tx_valid, 0);
        end
        @(posedge clk);
        #2;
        stall_a = 1'b0;
        refresh();
      end
      run_until_done("underrun");
    join
    chk("underrun_err", err_underrun, 1);
    chk("underrun_frames", frames_sent, 1);
    chk("underrun_no_oversize", err_oversize, 0);

    // Backpressure: ready 1,0,0,1 over a 4-byte frame on B.
    had_grant = 1'b0;
    load_frame(1'b1, 4, 8'hC0, 8'h01, 1'b0);
    build_expected();
    fork
      begin
        int n;
        n = 0;
        while (b_q.size() != 3 && n < 200) begin
          @(posedge clk);
          #2;
          n++;
        end
        tx_ready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          #1;
          chk("bp_no_ren", b_ren, 0);
          chk("bp_data_held", {tx_valid, tx_data}, {1'b1, 8'hC1});
        end
        @(posedge clk);
        #2;
        tx_ready = 1'b1;
      end
      run_until_done("backpressure");
    join
    chk("bp_frames", frames_sent, 2);

    // Reset in the middle of byte 2: outputs must clear with no clock edge.
    had_grant = 1'b0;
    load_frame(1'b0, 4, 8'hD0, 8'h01, 1'b0);
    build_expected();
    begin
      int n;
      n = 0;
      while (a_q.size() != 3 && n < 200) begin
        @(posedge clk);
        #2;
        n++;
      end
    end
    @(negedge clk);
    #1;
    chk("pre_reset_byte2", {tx_valid, tx_data}, {1'b1, 8'hD1});
    do_reset("rst_midframe");
    repeat (3) @(posedge clk);
    #2;
    chk("post_reset_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_fifo_arbiter.md
# frame_fifo_arbiter

- Shares one Ethernet TX byte stream between two frame FIFOs, A and B.
- Each FIFO is a synchronous first-word-fall-through FIFO: data is valid on its output whenever its empty flag is low, and one word pops per read-enable cycle.
- FIFO word format: data byte in bits [7:0], end-of-frame marker in bit [DATA_WIDTH-1].
- The block grants whole frames round-robin, enforces an inter-frame gap, guards against oversized frames, and reports errors and a frame count.

## Interface
- DATA_WIDTH, 9, FIFO word width; bit DATA_WIDTH-1 = EOF, bits [7:0] = byte.
- IFG_CYCLES, 12, idle cycles inserted after every frame; legal range ≥1.
- MAX_FRAME_LEN, 1522, maximum bytes per frame.
- LEN_WIDTH, 11, byte counter width; must satisfy 2^LEN_WIDTH > MAX_FRAME_LEN.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_dout  in  DATA_WIDTH  FIFO A head word.
- a_empty_flag  in  1  FIFO A empty.
- a_frame_avail  in  1  at least one complete frame is stored in FIFO A (from the writer side).
- a_ren  out  1  FIFO A read enable.
- b_dout, b_empty_flag, b_frame_avail, b_ren: same as the A ports, for FIFO B.
- tx_data  out  8  byte to the MAC.
- tx_valid  out  1  tx_data is valid.
- tx_last  out  1  tx_data is the final byte of the frame.
- tx_ready  in  1  MAC accepts the byte this cycle.
- grant  out  2  one-hot owner: [0]=A, [1]=B; 00 when no FIFO is owned.
- busy  out  1  state ≠ IDLE.
- err_underrun  out  1  sticky underrun error.
- err_oversize  out  1  sticky oversize error.
- frames_sent  out  16  frames completed on TX, wraps.

## Operation
**States:** IDLE, SEND, DRAIN, GAP.

**IDLE**
- Request per FIFO: req_x = x_frame_avail & ~x_empty_flag.
- Arbitration:
  - Single request: that FIFO is granted.
  - Both request: grant the FIFO other than last_served.
  - last_served resets to B, so A wins the first tie.
- On a grant: register grant, update last_served, clear the byte counter, go to SEND.

**SEND** (sel = granted FIFO)
- tx_valid = ~sel_empty_flag.
- tx_data = sel_dout[7:0].
- tx_last = sel_dout[DATA_WIDTH-1] | (len == MAX_FRAME_LEN-1).
- sel_ren = tx_valid & tx_ready. The non-selected ren is 0.
- Each handshake increments len.
- Handshake with tx_last:
  - frames_sent += 1.
  - If the EOF bit was set: go to GAP and load the gap counter with IFG_CYCLES.
  - If the EOF bit was clear (forced last): set err_oversize, go to DRAIN.
- sel_empty_flag high in SEND (mid-frame underrun):
  - tx_valid = 0.
  - err_underrun set on each such cycle; it stays set until reset.
  - State stays SEND.

**DRAIN**
- tx_valid = 0.
- sel_ren = ~sel_empty_flag: discard words until a word with EOF set is popped.
- After the EOF word is popped: load the gap counter, go to GAP.

**GAP**
- grant = 00, all ren = 0, tx_valid = 0.
- Gap counter decrements each cycle; at 1 → IDLE.
- GAP therefore lasts exactly IFG_CYCLES cycles.

**Other rules**
- tx_data and tx_last are don't-care while tx_valid = 0.
- Never assert a ren while that FIFO's empty flag is high.
- Width rules: len is LEN_WIDTH bits and cannot wrap (bounded by MAX_FRAME_LEN); frames_sent wraps 0xFFFF → 0.

## Timing
**Reset**
- rst_n low forces, asynchronously:
  - state = IDLE, grant = 00, last_served = B, len = 0.
  - err_underrun = 0, err_oversize = 0, frames_sent = 0.
  - a_ren = b_ren = 0, tx_valid = tx_last = 0.
- Reset mid-frame abandons the frame. Leftover FIFO contents are the writer's responsibility.

**Latency and spacing**
- Request seen in IDLE at cycle t → SEND at t+1, with tx_valid at t+1 if the FIFO is non-empty.
- Final byte handshake at t → GAP for cycles t+1 … t+IFG_CYCLES → IDLE at t+IFG_CYCLES+1.
- Earliest next first byte: t+IFG_CYCLES+2.
- Back-to-back bytes: one per cycle while tx_ready = 1 and the FIFO is non-empty. The tx_* outputs are combinational from the FIFO head.

**Boundary cases**
- tx_ready low: tx_valid, tx_data and tx_last are held, and ren = 0.
- A new frame_avail arriving during SEND or GAP is not evaluated until IDLE.
- A single-byte frame (EOF on the first word) is legal: SEND for one handshake, then GAP.

## Test plan
- **Single frame, A only:** A holds 3 bytes 11,22,33 (EOF on 33), tx_ready = 1. Required: tx 11,22,33 on consecutive cycles, tx_last on 33, grant = 01, frames_sent = 1, next grant no earlier than 14 cycles after 33.
- **Round-robin tie:** A and B each hold two 2-byte frames, both available from reset. Required: grant order A, B, A, B; frames_sent = 4; IFG of 12 idle cycles between frames.
- **Backpressure:** tx_ready toggled 1,0,0,1 during a 4-byte frame. Required: data held stable while ready = 0, no ren while ready = 0, no byte lost or duplicated.
- **Underrun:** A empties after 2 of 4 bytes for 3 cycles, then refills. Required: tx_valid low for those 3 cycles, err_underrun = 1, frame completes with correct bytes.
- **Oversize:** MAX_FRAME_LEN = 8, A frame of 10 bytes. Required: 8 bytes sent with tx_last on byte 8, err_oversize = 1, bytes 9–10 popped with tx_valid = 0, then GAP.
- **Reset mid-frame:** rst_n asserted low during byte 2. Required: all outputs at reset values immediately, with no clock edge needed.
